uart_rx_param: RTL and testbench

Parametrised UART receiver, the next generation of the fixed 8N1 receiver feeding `RX_Byte` in the VGA/UART top. It supports:
- configurable bit period, data width (5–9), parity (none/odd/even) and 1 or 2 stop bits;
- an internal 2-flop synchroniser, false-start rejection, and parity/framing error flags;
- break (line-held-low) detection.

It sits between the board `RX` pin and downstream command decoders, such as the seven-segment and VGA colour logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_param.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
package uart_pkg;

  // Parity selection encodings for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 25 MHz system clock, 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 217;

  // Receiver FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BRK   = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages reset to the line's idle level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start-bit validation, LSB-first data,
// optional parity, 1 or 2 stop bits, framing error and break detection.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on rx_s
// START    | half a bit into the start bit, confirming it is still low
// DATA     | sampling DATA_BITS data bits at bit centres
// PAR      | sampling the parity bit
// STOP     | sampling STOP_BITS stop bits, flagging any low sample
// BRK      | line held low after the frame, waiting for it to go high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX,
  output logic                 RX_DV,
  output logic [DATA_BITS-1:0] RX_BYTE,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BREAK,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = 4;
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic             PAR_IS_ODD = (PARITY == PAR_ODD);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  rx_state_t            state;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 dv_pend;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (RX),
    .q     (rx_s)
  );

  // Receive FSM and datapath; the frame result is published one cycle
  // after the last stop sample so RX_DV and its data arrive together
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      dv_pend    <= 1'b0;
      RX_DV      <= 1'b0;
      RX_BYTE    <= '0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      RX_DV   <= dv_pend;
      dv_pend <= 1'b0;
      if (dv_pend) begin
        RX_BYTE    <= shreg;
        PARITY_ERR <= par_err_q;
        FRAME_ERR  <= frm_err_q;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt       <= '0;
            bit_idx   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            // A start bit that has gone high by mid-bit was a glitch
            state     <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= HAS_PAR ? ST_PAR : ST_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_PAR: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            bit_idx   <= '0;
            par_err_q <= (^{shreg, rx_s}) != PAR_IS_ODD;
            state     <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!rx_s) frm_err_q <= 1'b1;
            if (bit_idx == STOP_LAST) begin
              dv_pend <= 1'b1;
              // A low final stop bit may be the start of a break
              state   <= rx_s ? ST_IDLE : ST_BRK;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_BRK: begin
          if (rx_s) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY  = (state != ST_IDLE);
  assign BREAK = (state == ST_BRK);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 7E2, 9O1) driven by a
// bit-level serial driver; expectations come from the frame timing rules.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int H   = (CPB - 1) / 2;

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } ev_t;

  logic CLK = 1'b0;
  logic RST_N;
  logic rx_a, rx_b, rx_c;

  logic       dv_a, pe_a, fe_a, brk_a, busy_a;
  logic [7:0] byte_a;
  logic       dv_b, pe_b, fe_b, brk_b, busy_b;
  logic [6:0] byte_b;
  logic       dv_c, pe_c, fe_c, brk_c, busy_c;
  logic [8:0] byte_c;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .CLK(CLK), .RST_N(RST_N), .RX(rx_a), .RX_DV(dv_a), .RX_BYTE(byte_a),
    .PARITY_ERR(pe_a), .FRAME_ERR(fe_a), .BREAK(brk_a), .BUSY(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .CLK(CLK), .RST_N(RST_N), .RX(rx_b), .RX_DV(dv_b), .RX_BYTE(byte_b),
    .PARITY_ERR(pe_b), .FRAME_ERR(fe_b), .BREAK(brk_b), .BUSY(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_c (
    .CLK(CLK), .RST_N(RST_N), .RX(rx_c), .RX_DV(dv_c), .RX_BYTE(byte_c),
    .PARITY_ERR(pe_c), .FRAME_ERR(fe_c), .BREAK(brk_c), .BUSY(busy_c));

  always #5 CLK = ~CLK;

  // Edge counter: after posedge k, cyc == k
  always @(posedge CLK) cyc <= cyc + 1;

  // Record every cycle in which RX_DV is high, with its payload
  always @(negedge CLK) begin
    ev_t ev;
    if (dv_a === 1'b1) begin
      ev.cyc = cyc; ev.data = {1'b0, byte_a}; ev.pe = pe_a; ev.fe = fe_a;
      qa.push_back(ev);
    end
    if (dv_b === 1'b1) begin
      ev.cyc = cyc; ev.data = {2'b0, byte_b}; ev.pe = pe_b; ev.fe = fe_b;
      qb.push_back(ev);
    end
    if (dv_c === 1'b1) begin
      ev.cyc = cyc; ev.data = byte_c; ev.pe = pe_c; ev.fe = fe_c;
      qc.push_back(ev);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  function automatic int qsize(input int w);
    case (w)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic qpop(input int w, output ev_t ev);
    case (w)
      0: ev = qa.pop_front();
      1: ev = qb.pop_front();
      default: ev = qc.pop_front();
    endcase
  endtask

  // Spec timing: RX_DV is visible in the cycle after edge E(4+H+N*CPB)
  function automatic int dv_cycle(input int e0, input int dbits, input int par, input int nstop);
    int n;
    n = dbits + ((par != 0) ? 1 : 0) + nstop;
    return e0 + 4 + H + n * CPB;
  endfunction

  // Drive one serial frame, starting at a falling clock edge. e0 is the
  // first rising edge at which the pin reads the start bit.
  task automatic send(input int w, input logic [8:0] d, input int dbits, input int par,
                      input bit bad_par, input int nstop, input bit stop_low, output int e0);
    logic p;
    e0 = cyc + 1;
    set_rx(w, 1'b0);
    repeat (CPB) @(negedge CLK);
    p = 1'b0;
    for (int i = 0; i < dbits; i++) begin
      set_rx(w, d[i]);
      p = p ^ d[i];
      repeat (CPB) @(negedge CLK);
    end
    if (par != 0) begin
      p = (par == 1) ? ~p : p;
      set_rx(w, p ^ bad_par);
      repeat (CPB) @(negedge CLK);
    end
    for (int s = 0; s < nstop; s++) begin
      set_rx(w, stop_low ? 1'b0 : 1'b1);
      repeat (CPB) @(negedge CLK);
    end
  endtask

  task automatic expect_frame(input string tag, input int w, input int exp_cyc,
                              input logic [8:0] exp_d, input logic exp_pe, input logic exp_fe);
    ev_t  ev;
    int   waited;
    logic got;
    waited = 0;
    while (qsize(w) == 0 && waited < 600) begin
      @(negedge CLK);
      waited++;
    end
    got = (qsize(w) != 0);
    check({tag, "_arrived"}, {31'b0, got}, 32'd1);
    if (got) begin
      qpop(w, ev);
      check({tag, "_cycle"}, ev.cyc, exp_cyc);
      check({tag, "_data"}, {23'b0, ev.data}, {23'b0, exp_d});
      check({tag, "_perr"}, {31'b0, ev.pe}, {31'b0, exp_pe});
      check({tag, "_ferr"}, {31'b0, ev.fe}, {31'b0, exp_fe});
    end
  endtask

  initial begin
    int         e0;
    int         e_arr[6];
    logic [8:0] d_arr[6];
    logic       b_arr[6];

    RST_N = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    repeat (4) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset state
    check("rst_dv_a",    {31'b0, dv_a}, 0);
    check("rst_byte_a",  {24'b0, byte_a}, 0);
    check("rst_perr_a",  {31'b0, pe_a}, 0);
    check("rst_ferr_a",  {31'b0, fe_a}, 0);
    check("rst_break_a", {31'b0, brk_a}, 0);
    check("rst_busy_a",  {31'b0, busy_a}, 0);
    check("rst_byte_b",  {25'b0, byte_b}, 0);
    check("rst_busy_b",  {31'b0, busy_b}, 0);
    check("rst_break_b", {31'b0, brk_b}, 0);
    check("rst_byte_c",  {23'b0, byte_c}, 0);
    check("rst_busy_c",  {31'b0, busy_c}, 0);
    check("rst_break_c", {31'b0, brk_c}, 0);

    // 1: 8N1 0xA5
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b0, e0);
    check("t1_e155", dv_cycle(e0, 8, 0, 1) - e0, 155);
    expect_frame("t1", 0, dv_cycle(e0, 8, 0, 1), 9'h0A5, 1'b0, 1'b0);
    repeat (20) @(negedge CLK);
    check("t1_hold_byte", {24'b0, byte_a}, 32'h0A5);
    check("t1_single_dv", qa.size(), 0);

    // 2: 7E2 0x41, good then bad parity
    send(1, 9'h041, 7, 2, 1'b0, 2, 1'b0, e0);
    expect_frame("t2_good", 1, dv_cycle(e0, 7, 2, 2), 9'h041, 1'b0, 1'b0);
    send(1, 9'h041, 7, 2, 1'b1, 2, 1'b0, e0);
    expect_frame("t2_bad", 1, dv_cycle(e0, 7, 2, 2), 9'h041, 1'b1, 1'b0);

    // 3: 8N1 0x3C with low stop bit, then line held low (break)
    send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, e0);
    repeat (40 * CPB) @(negedge CLK);
    expect_frame("t3", 0, dv_cycle(e0, 8, 0, 1), 9'h03C, 1'b0, 1'b1);
    check("t3_break_held", {31'b0, brk_a}, 1);
    check("t3_busy_held",  {31'b0, busy_a}, 1);
    check("t3_no_extra_dv", qa.size(), 0);
    rx_a = 1'b1;
    repeat (4) @(negedge CLK);
    check("t3_break_clear", {31'b0, brk_a}, 0);
    check("t3_busy_clear",  {31'b0, busy_a}, 0);
    repeat (CPB) @(negedge CLK);
    check("t3_no_dv_after", qa.size(), 0);

    // 4: 4-cycle glitch; START sample at E(3+H) rejects it
    e0 = cyc + 1;
    rx_a = 1'b0;
    repeat (4) @(negedge CLK);
    rx_a = 1'b1;
    repeat (2) @(negedge CLK);
    check("t4_busy_in_start", {31'b0, busy_a}, 1);
    repeat (3 + H - (cyc - e0)) @(negedge CLK);
    check("t4_glitch_cycle", cyc - e0, 3 + H);
    check("t4_idle", {31'b0, busy_a}, 0);
    repeat (12 * CPB) @(negedge CLK);
    check("t4_no_dv", qa.size(), 0);

    // 5: 9O1 back-to-back
    d_arr[0] = 9'h1FF; d_arr[1] = 9'h000; d_arr[2] = 9'h155;
    for (int k = 0; k < 3; k++) send(2, d_arr[k], 9, 1, 1'b0, 1, 1'b0, e_arr[k]);
    for (int k = 0; k < 3; k++)
      expect_frame("t5", 2, dv_cycle(e_arr[k], 9, 1, 1), d_arr[k], 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check("t5_three_only", qc.size(), 0);

    // Random 8N1 back-to-back bytes
    for (int k = 0; k < 6; k++) begin
      d_arr[k] = 9'($urandom_range(0, 255));
      send(0, d_arr[k], 8, 0, 1'b0, 1, 1'b0, e_arr[k]);
    end
    for (int k = 0; k < 6; k++)
      expect_frame("rnd_8n1", 0, dv_cycle(e_arr[k], 8, 0, 1), d_arr[k], 1'b0, 1'b0);

    // Random 7E2 with random parity corruption
    for (int k = 0; k < 4; k++) begin
      d_arr[k] = 9'($urandom_range(0, 127));
      b_arr[k] = 1'($urandom_range(0, 1));
      send(1, d_arr[k], 7, 2, b_arr[k], 2, 1'b0, e_arr[k]);
    end
    for (int k = 0; k < 4; k++)
      expect_frame("rnd_7e2", 1, dv_cycle(e_arr[k], 7, 2, 2), d_arr[k], b_arr[k], 1'b0);

    // 6: reset pulse during DATA bit 4 of an 8N1 frame, then 0x5A
    repeat (CPB) @(negedge CLK);
    fork
      send(0, 9'h0F0, 8, 0, 1'b0, 1, 1'b0, e0);
      begin
        repeat (3 + H + 4 * CPB + 9) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
      end
    join
    repeat (3 * CPB) @(negedge CLK);
    check("t6_aborted_no_dv", qa.size(), 0);
    check("t6_idle", {31'b0, busy_a}, 0);
    send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0, e0);
    expect_frame("t6", 0, dv_cycle(e0, 8, 0, 1), 9'h05A, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check("t6_single_dv", qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
